// File: rtl/predicate_predictor_array.sv
// Bank of saturating-counter predicate predictors with multi-port training,
// per-predicate speculation tracking and registered mispredict pulses.
module predicate_predictor_array #(
  parameter int NUM_PREDICATES  = 8,
  parameter int COUNTER_WIDTH   = 2,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int DI_WIDTH        = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  flush,
  input  logic [NUM_WRITE_PORTS-1:0]            write_valid,
  input  logic [NUM_WRITE_PORTS*DI_WIDTH-1:0]   write_di,
  input  logic [NUM_WRITE_PORTS-1:0]            write_value,
  input  logic                                  spec_valid,
  input  logic [$clog2(NUM_PREDICATES)-1:0]     spec_index,
  output logic [NUM_PREDICATES-1:0]             predictions,
  output logic [NUM_PREDICATES-1:0]             confident,
  output logic [NUM_PREDICATES-1:0]             pending,
  output logic [NUM_PREDICATES-1:0]             mispredict
);

  localparam int IDX_W = $clog2(NUM_PREDICATES);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
  // Weakly-false start point: 2^(W-1)-1, which is 0 when W==1.
  localparam logic [COUNTER_WIDTH-1:0] CNT_INIT = CNT_MAX >> 1;

  logic [COUNTER_WIDTH-1:0] counter_reg  [NUM_PREDICATES];
  logic [COUNTER_WIDTH-1:0] counter_next [NUM_PREDICATES];
  logic [NUM_PREDICATES-1:0] pending_reg, pending_next;
  logic [NUM_PREDICATES-1:0] captured_reg, captured_next;
  logic [NUM_PREDICATES-1:0] mispredict_reg;
  logic [NUM_PREDICATES-1:0] hit, hit_value, resolving;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PREDICATES; gi++) begin : g_pred
      logic                     win_hit;
      logic                     win_value;
      logic [COUNTER_WIDTH-1:0] cnt;

      assign cnt = counter_reg[gi];

      // Scan ports high to low so the lowest-numbered matching port wins.
      always_comb begin
        win_hit   = 1'b0;
        win_value = 1'b0;
        for (int p = NUM_WRITE_PORTS - 1; p >= 0; p--) begin
          if (write_valid[p] && (write_di[p*DI_WIDTH +: IDX_W] == IDX_W'(gi))) begin
            win_hit   = 1'b1;
            win_value = write_value[p];
          end
        end
      end

      assign hit[gi]       = win_hit;
      assign hit_value[gi] = win_value;
      assign resolving[gi] = win_hit && pending_reg[gi];

      always_comb begin
        counter_next[gi] = cnt;
        if (win_hit) begin
          if (win_value) begin
            if (cnt != CNT_MAX) counter_next[gi] = cnt + COUNTER_WIDTH'(1);
          end else begin
            if (cnt != '0) counter_next[gi] = cnt - COUNTER_WIDTH'(1);
          end
        end
      end

      // A resolving write frees the slot before a same-cycle speculation claims it.
      always_comb begin
        pending_next[gi]  = pending_reg[gi] && !win_hit;
        captured_next[gi] = captured_reg[gi];
        if (flush) begin
          pending_next[gi] = 1'b0;
        end else if (spec_valid && (spec_index == IDX_W'(gi)) && !pending_next[gi]) begin
          pending_next[gi]  = 1'b1;
          captured_next[gi] = cnt[COUNTER_WIDTH-1];
        end
      end

      assign predictions[gi] = cnt[COUNTER_WIDTH-1];
      assign confident[gi]   = (cnt == '0) || (cnt == CNT_MAX);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PREDICATES; i++) counter_reg[i] <= CNT_INIT;
      pending_reg    <= '0;
      captured_reg   <= '0;
      mispredict_reg <= '0;
    end else if (!enable) begin
      mispredict_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_PREDICATES; i++) counter_reg[i] <= counter_next[i];
      pending_reg    <= pending_next;
      captured_reg   <= captured_next;
      mispredict_reg <= flush ? '0 : (resolving & (hit_value ^ captured_reg));
    end
  end

  assign pending    = pending_reg;
  assign mispredict = mispredict_reg;

endmodule
